// File: rtl/xg_tx_frame_gen.sv
// Burst frame generator for the 10G MAC transmit client port.
// Emits header + incrementing payload frames with start/ack handshake and gaps.
module xg_tx_frame_gen (
    input  logic        tx_clk0,
    input  logic        reset_n,
    input  logic        gen_start,
    input  logic        gen_stop,
    input  logic [47:0] cfg_dst_mac,
    input  logic [47:0] cfg_src_mac,
    input  logic [15:0] cfg_ethertype,
    input  logic [13:0] cfg_frame_len,
    input  logic [31:0] cfg_frame_count,
    input  logic [15:0] cfg_gap,
    output logic [63:0] tx_data,
    output logic [7:0]  tx_data_valid,
    output logic        tx_start,
    input  logic        tx_ack,
    output logic        tx_underrun,
    output logic        gen_busy,
    output logic        gen_done,
    output logic [31:0] frames_sent
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_ACK,
        S_DATA,
        S_GAP
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [47:0] r_dst;
    logic [47:0] r_src;
    logic [15:0] r_etype;
    logic [10:0] r_nwords;
    logic [7:0]  r_last_valid;
    logic [31:0] r_count;
    logic [15:0] r_gap;
    logic [15:0] r_gap_cnt;
    logic [7:0]  r_seq;
    logic [10:0] r_idx;
    logic [31:0] r_frames_sent;
    logic        r_stop_pend;
    logic        r_done;

    logic [13:0] w_len;
    logic [10:0] w_nwords;
    logic [7:0]  w_last_valid;
    logic [15:0] w_gap;
    logic        w_accept;
    logic        w_last_word;
    logic        w_last_frame;
    logic        w_gap_end;
    logic        w_ack_now;
    logic [31:0] w_frames_inc;
    logic [63:0] w_word;
    logic [63:0] w_tx_data;
    logic [7:0]  w_tx_valid;
    logic        w_tx_start;

    // Configuration derived at the moment a burst is accepted
    assign w_len = (cfg_frame_len < 14'd60)   ? 14'd60 :
                   (cfg_frame_len > 14'd9600) ? 14'd9600 :
                   cfg_frame_len;

    assign w_nwords = w_len[13:3] + {10'd0, |w_len[2:0]};

    assign w_last_valid = (w_len[2:0] == 3'd0) ? 8'hFF :
                          (8'hFF >> (4'd8 - {1'b0, w_len[2:0]}));

    assign w_gap = (cfg_gap == 16'd0) ? 16'd1 : cfg_gap;

    assign w_accept     = (r_state == S_IDLE) && gen_start;
    assign w_ack_now    = ((r_state == S_START) || (r_state == S_WAIT_ACK))
                          && tx_ack;
    assign w_last_word  = (r_state == S_DATA)
                          && (r_idx == r_nwords - 11'd1);
    assign w_frames_inc = r_frames_sent + 32'd1;
    assign w_last_frame = r_stop_pend
                          || ((r_count != 32'd0) && (w_frames_inc == r_count));
    assign w_gap_end    = (r_state == S_GAP)
                          && (r_gap_cnt == r_gap - 16'd1);

    // Byte b of the frame lives in word b/8, lane b%8
    for (genvar i = 0; i < 8; i++) begin : g_lane
        logic [13:0] w_b;
        logic [7:0]  w_byte;

        assign w_b = {r_idx, 3'(i)};

        always_comb begin
            w_byte = w_b[7:0] - 8'd14 + r_seq;
            case (w_b)
                14'd0:   w_byte = r_dst[47:40];
                14'd1:   w_byte = r_dst[39:32];
                14'd2:   w_byte = r_dst[31:24];
                14'd3:   w_byte = r_dst[23:16];
                14'd4:   w_byte = r_dst[15:8];
                14'd5:   w_byte = r_dst[7:0];
                14'd6:   w_byte = r_src[47:40];
                14'd7:   w_byte = r_src[39:32];
                14'd8:   w_byte = r_src[31:24];
                14'd9:   w_byte = r_src[23:16];
                14'd10:  w_byte = r_src[15:8];
                14'd11:  w_byte = r_src[7:0];
                14'd12:  w_byte = r_etype[15:8];
                14'd13:  w_byte = r_etype[7:0];
                default: w_byte = w_b[7:0] - 8'd14 + r_seq;
            endcase
        end

        assign w_word[8*i +: 8] = w_byte;
    end

    always_ff @(posedge tx_clk0) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_tx_start = 1'b0;
        w_tx_data  = 64'd0;
        w_tx_valid = 8'd0;
        case (r_state)
            S_IDLE: begin
                if (gen_start) w_next = S_START;
            end
            S_START: begin
                w_tx_start = 1'b1;
                w_tx_data  = w_word;
                w_tx_valid = 8'hFF;
                w_next     = tx_ack ? S_DATA : S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                w_tx_data  = w_word;
                w_tx_valid = 8'hFF;
                if (tx_ack) w_next = S_DATA;
            end
            S_DATA: begin
                w_tx_data  = w_word;
                w_tx_valid = w_last_word ? r_last_valid : 8'hFF;
                if (w_last_word) begin
                    w_next = w_last_frame ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (w_gap_end) w_next = S_START;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge tx_clk0) begin
        if (!reset_n) begin
            r_dst         <= 48'd0;
            r_src         <= 48'd0;
            r_etype       <= 16'd0;
            r_nwords      <= 11'd0;
            r_last_valid  <= 8'd0;
            r_count       <= 32'd0;
            r_gap         <= 16'd0;
            r_gap_cnt     <= 16'd0;
            r_seq         <= 8'd0;
            r_idx         <= 11'd0;
            r_frames_sent <= 32'd0;
            r_stop_pend   <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_accept) begin
                r_dst         <= cfg_dst_mac;
                r_src         <= cfg_src_mac;
                r_etype       <= cfg_ethertype;
                r_nwords      <= w_nwords;
                r_last_valid  <= w_last_valid;
                r_count       <= cfg_frame_count;
                r_gap         <= w_gap;
                r_gap_cnt     <= 16'd0;
                r_seq         <= 8'd0;
                r_idx         <= 11'd0;
                r_frames_sent <= 32'd0;
            end

            // Stop is sticky for the rest of the burst only
            if (r_state == S_IDLE) begin
                r_stop_pend <= 1'b0;
            end else if (gen_stop) begin
                r_stop_pend <= 1'b1;
            end

            if (w_ack_now) begin
                r_idx <= 11'd1;
            end

            if (r_state == S_DATA) begin
                if (w_last_word) begin
                    r_idx         <= 11'd0;
                    r_gap_cnt     <= 16'd0;
                    r_frames_sent <= w_frames_inc;
                    r_done        <= w_last_frame;
                end else begin
                    r_idx <= r_idx + 11'd1;
                end
            end

            if (r_state == S_GAP) begin
                if (w_gap_end) begin
                    r_gap_cnt <= 16'd0;
                    r_seq     <= r_seq + 8'd1;
                end else begin
                    r_gap_cnt <= r_gap_cnt + 16'd1;
                end
            end
        end
    end

    assign tx_data       = w_tx_data;
    assign tx_data_valid = w_tx_valid;
    assign tx_start      = w_tx_start;
    assign tx_underrun   = 1'b0;
    assign gen_busy      = (r_state != S_IDLE);
    assign gen_done      = r_done;
    assign frames_sent   = r_frames_sent;

endmodule

// File: tb/tb_xg_tx_frame_gen.sv
// Directed bench for xg_tx_frame_gen: frame content, handshake, bursts,
// stop, restart and mid-frame reset.
module tb_xg_tx_frame_gen;

    logic        tx_clk0 = 1'b0;
    logic        reset_n;
    logic        gen_start;
    logic        gen_stop;
    logic [47:0] cfg_dst_mac;
    logic [47:0] cfg_src_mac;
    logic [15:0] cfg_ethertype;
    logic [13:0] cfg_frame_len;
    logic [31:0] cfg_frame_count;
    logic [15:0] cfg_gap;
    logic [63:0] tx_data;
    logic [7:0]  tx_data_valid;
    logic        tx_start;
    logic        tx_ack;
    logic        tx_underrun;
    logic        gen_busy;
    logic        gen_done;
    logic [31:0] frames_sent;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [47:0] e_dst;
    logic [47:0] e_src;
    logic [15:0] e_et;

    always #5 tx_clk0 = ~tx_clk0;
    always @(posedge tx_clk0) cyc <= cyc + 1;

    xg_tx_frame_gen dut (
        .tx_clk0         (tx_clk0),
        .reset_n         (reset_n),
        .gen_start       (gen_start),
        .gen_stop        (gen_stop),
        .cfg_dst_mac     (cfg_dst_mac),
        .cfg_src_mac     (cfg_src_mac),
        .cfg_ethertype   (cfg_ethertype),
        .cfg_frame_len   (cfg_frame_len),
        .cfg_frame_count (cfg_frame_count),
        .cfg_gap         (cfg_gap),
        .tx_data         (tx_data),
        .tx_data_valid   (tx_data_valid),
        .tx_start        (tx_start),
        .tx_ack          (tx_ack),
        .tx_underrun     (tx_underrun),
        .gen_busy        (gen_busy),
        .gen_done        (gen_done),
        .frames_sent     (frames_sent)
    );

    task automatic step();
        @(posedge tx_clk0);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_word(input int w, input logic [7:0] seq);
        logic [63:0] r;
        logic [7:0]  v;
        int          b;
        r = 64'd0;
        for (int l = 0; l < 8; l++) begin
            b = w * 8 + l;
            if (b < 6)       v = e_dst[8*(5-b) +: 8];
            else if (b < 12) v = e_src[8*(11-b) +: 8];
            else if (b == 12) v = e_et[15:8];
            else if (b == 13) v = e_et[7:0];
            else             v = 8'(b - 14) + seq;
            r[8*l +: 8] = v;
        end
        return r;
    endfunction

    function automatic logic [63:0] mask64(input logic [7:0] v);
        logic [63:0] m;
        for (int l = 0; l < 8; l++) m[8*l +: 8] = {8{v[l]}};
        return m;
    endfunction

    // Handles one frame from tx_start through its last word, checking every word
    task automatic send_frame(input int nw, input logic [7:0] lastv,
                              input logic [7:0] seq, input int ack_dly,
                              input int stop_at, input int bstart_at,
                              output int scyc);
        int          k;
        logic [7:0]  ev;
        k = 0;
        while (tx_start !== 1'b1 && k < 64) begin
            step();
            k++;
        end
        chk("start_seen", tx_start, 1);
        scyc = cyc;
        for (int d = 0; d <= ack_dly; d++) begin
            chk("w0_data", tx_data, exp_word(0, seq));
            chk("w0_valid", tx_data_valid, 8'hFF);
            chk("w0_start", tx_start, (d == 0));
            if (d == ack_dly) tx_ack = 1'b1;
            step();
            tx_ack = 1'b0;
        end
        for (int w = 1; w < nw; w++) begin
            ev = (w == nw - 1) ? lastv : 8'hFF;
            chk("data_valid", tx_data_valid, ev);
            chk("data_word", tx_data & mask64(ev), exp_word(w, seq) & mask64(ev));
            gen_stop  = (w == stop_at);
            gen_start = (w == bstart_at);
            step();
            gen_stop  = 1'b0;
            gen_start = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1, s2;

        reset_n         = 1'b0;
        gen_start       = 1'b0;
        gen_stop        = 1'b0;
        tx_ack          = 1'b0;
        cfg_dst_mac     = 48'd0;
        cfg_src_mac     = 48'd0;
        cfg_ethertype   = 16'd0;
        cfg_frame_len   = 14'd0;
        cfg_frame_count = 32'd0;
        cfg_gap         = 16'd0;
        repeat (3) step();

        chk("rst_data", tx_data, 0);
        chk("rst_valid", tx_data_valid, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_underrun", tx_underrun, 0);
        chk("rst_busy", gen_busy, 0);
        chk("rst_done", gen_done, 0);
        chk("rst_frames", frames_sent, 0);
        reset_n = 1'b1;
        step();

        // Minimum frame, ack three cycles after tx_start
        e_dst = 48'h001122334455;
        e_src = 48'h66778899AABB;
        e_et  = 16'h0800;
        cfg_dst_mac     = e_dst;
        cfg_src_mac     = e_src;
        cfg_ethertype   = e_et;
        cfg_frame_len   = 14'd60;
        cfg_frame_count = 32'd1;
        cfg_gap         = 16'd0;
        gen_start = 1'b1;
        step();
        gen_start = 1'b0;
        chk("t1_busy", gen_busy, 1);
        chk("t1_w0_hand", tx_data, 64'h7766554433221100);
        send_frame(8, 8'h0F, 8'd0, 3, -1, -1, s0);
        chk("t1_done", gen_done, 1);
        chk("t1_busy_end", gen_busy, 0);
        chk("t1_frames", frames_sent, 1);
        chk("t1_idle_valid", tx_data_valid, 0);
        step();
        chk("t1_done_pulse", gen_done, 0);

        // Full last word, immediate ack
        cfg_frame_len = 14'd64;
        gen_start = 1'b1;
        step();
        gen_start = 1'b0;
        send_frame(8, 8'hFF, 8'd0, 0, -1, -1, s0);
        chk("t2_done", gen_done, 1);
        chk("t2_frames", frames_sent, 1);

        // Length clamp, short and long
        cfg_frame_len = 14'd20;
        gen_start = 1'b1;
        step();
        gen_start = 1'b0;
        send_frame(8, 8'h0F, 8'd0, 0, -1, -1, s0);
        chk("t3_done", gen_done, 1);
        cfg_frame_len = 14'd12000;
        gen_start = 1'b1;
        step();
        gen_start = 1'b0;
        send_frame(1200, 8'hFF, 8'd0, 1, -1, -1, s0);
        chk("t3_long_done", gen_done, 1);
        chk("t3_long_busy", gen_busy, 0);

        // Burst of three with gap 5
        e_dst = 48'hA1B2C3D4E5F6;
        e_src = 48'h102030405060;
        e_et  = 16'h88B5;
        cfg_dst_mac     = e_dst;
        cfg_src_mac     = e_src;
        cfg_ethertype   = e_et;
        cfg_frame_len   = 14'd60;
        cfg_frame_count = 32'd3;
        cfg_gap         = 16'd5;
        gen_start = 1'b1;
        step();
        gen_start = 1'b0;
        send_frame(8, 8'h0F, 8'd0, 0, -1, -1, s0);
        chk("t4_gap_valid", tx_data_valid, 0);
        chk("t4_gap_data", tx_data, 0);
        chk("t4_gap_busy", gen_busy, 1);
        chk("t4_gap_done", gen_done, 0);
        chk("t4_frames1", frames_sent, 1);
        send_frame(8, 8'h0F, 8'd1, 0, -1, -1, s1);
        chk("t4_space1", s1 - s0, 13);
        send_frame(8, 8'h0F, 8'd2, 0, -1, -1, s2);
        chk("t4_space2", s2 - s1, 13);
        chk("t4_done", gen_done, 1);
        chk("t4_frames", frames_sent, 3);

        // Gap 0 behaves as gap 1, then restart on the done cycle
        cfg_frame_count = 32'd2;
        cfg_gap         = 16'd0;
        gen_start = 1'b1;
        step();
        gen_start = 1'b0;
        send_frame(8, 8'h0F, 8'd0, 0, -1, -1, s0);
        send_frame(8, 8'h0F, 8'd1, 0, -1, -1, s1);
        chk("t5_space", s1 - s0, 9);
        chk("t5_done", gen_done, 1);
        chk("t5_frames", frames_sent, 2);
        cfg_frame_count = 32'd1;
        gen_start = 1'b1;
        step();
        gen_start = 1'b0;
        chk("t5_restart", tx_start, 1);
        chk("t5_restart_frames", frames_sent, 0);
        send_frame(8, 8'h0F, 8'd0, 0, -1, -1, s0);
        chk("t5_restart_done", gen_done, 1);

        // Continuous mode ended by stop in frame 2
        cfg_frame_len   = 14'd64;
        cfg_frame_count = 32'd0;
        cfg_gap         = 16'd2;
        gen_stop = 1'b1;
        step();
        gen_stop  = 1'b0;
        gen_start = 1'b1;
        gen_stop  = 1'b1;
        step();
        gen_start = 1'b0;
        gen_stop  = 1'b0;
        send_frame(8, 8'hFF, 8'd0, 0, -1, 3, s0);
        chk("t6_gap_busy", gen_busy, 1);
        chk("t6_gap_done", gen_done, 0);
        send_frame(8, 8'hFF, 8'd1, 1, 4, -1, s1);
        chk("t6_space", s1 - s0, 10);
        chk("t6_done", gen_done, 1);
        chk("t6_busy", gen_busy, 0);
        chk("t6_frames", frames_sent, 2);
        step();
        chk("t6_no_more_start", tx_start, 0);
        chk("t6_idle_busy", gen_busy, 0);

        // Reset in the middle of a frame
        cfg_frame_len   = 14'd60;
        cfg_frame_count = 32'd1;
        gen_start = 1'b1;
        step();
        gen_start = 1'b0;
        tx_ack    = 1'b1;
        step();
        tx_ack    = 1'b0;
        step();
        step();
        chk("t7_mid_valid", tx_data_valid, 8'hFF);
        reset_n = 1'b0;
        step();
        chk("t7_rst_data", tx_data, 0);
        chk("t7_rst_valid", tx_data_valid, 0);
        chk("t7_rst_start", tx_start, 0);
        chk("t7_rst_busy", gen_busy, 0);
        chk("t7_rst_done", gen_done, 0);
        chk("t7_rst_underrun", tx_underrun, 0);
        reset_n = 1'b1;
        step();
        chk("t7_idle_start", tx_start, 0);
        gen_start = 1'b1;
        step();
        gen_start = 1'b0;
        send_frame(8, 8'h0F, 8'd0, 2, -1, -1, s0);
        chk("t7_done", gen_done, 1);
        chk("t7_frames", frames_sent, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
